// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: base opcodes, the canonical NOP and the fetch FSM encoding.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

  function automatic logic is_supported(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_STORE, OP_BRANCH,
      OP_LUI, OP_AUIPC, OP_JAL, OP_REG, OP_REG32: is_supported = 1'b1;
      default:                                    is_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: sign-extends the I/S/B/U/J immediate of an instruction word to XLEN bits.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     ir,
  output logic [XLEN-1:0] imm
);

  // The sign bit is always ir[31], whatever the format.
  always_comb begin
    imm = '0;
    case (ir[6:0])
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR:
        imm = {{(XLEN-12){ir[31]}}, ir[31:20]};
      OP_STORE:
        imm = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
      OP_BRANCH:
        imm = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {{(XLEN-32){ir[31]}}, ir[31:12], 12'b0};
      OP_JAL:
        imm = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode front end: IDLE/REQ/HOLD fetch FSM, instruction register and field decode.
// Optional memory-wait timeout is enabled by defining IFD_TIMEOUT_EN (adds the MAX_WAIT parameter).
module instr_fetch_decode
  import riscv_pkg::*;
#(
  parameter int XLEN = 64
`ifdef IFD_TIMEOUT_EN
  , parameter int MAX_WAIT = 15
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_start,
  input  logic [XLEN-1:0] pc_in,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            busy,
  output logic            instr_valid,
  output logic            fetch_err,
  output logic            illegal,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm
);

  fetch_state_t state;
  logic [31:0]  ir;
`ifdef IFD_TIMEOUT_EN
  logic [7:0]   wait_cnt;
`endif

  // A misaligned start never touches memory: it lands directly in HOLD with a NOP and an error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      ir          <= NOP_INSTR;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      busy        <= 1'b0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
`ifdef IFD_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (fetch_start) begin
            imem_addr <= pc_in;
            if (pc_in[1:0] != 2'b00) begin
              state       <= ST_HOLD;
              ir          <= NOP_INSTR;
              instr_valid <= 1'b1;
              fetch_err   <= 1'b1;
            end else begin
              state       <= ST_REQ;
              imem_req    <= 1'b1;
              busy        <= 1'b1;
              instr_valid <= 1'b0;
              fetch_err   <= 1'b0;
`ifdef IFD_TIMEOUT_EN
              wait_cnt    <= '0;
`endif
            end
          end
        end
        ST_REQ: begin
          if (imem_ready) begin
            state       <= ST_HOLD;
            ir          <= imem_rdata;
            imem_req    <= 1'b0;
            busy        <= 1'b0;
            instr_valid <= 1'b1;
          end
`ifdef IFD_TIMEOUT_EN
          else if (wait_cnt == 8'(MAX_WAIT)) begin
            state       <= ST_HOLD;
            ir          <= NOP_INSTR;
            imem_req    <= 1'b0;
            busy        <= 1'b0;
            instr_valid <= 1'b1;
            fetch_err   <= 1'b1;
          end else begin
            wait_cnt    <= wait_cnt + 8'd1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign opcode  = ir[6:0];
  assign rd      = ir[11:7];
  assign funct3  = ir[14:12];
  assign rs1     = ir[19:15];
  assign rs2     = ir[24:20];
  assign funct7  = ir[31:25];
  assign illegal = instr_valid & ~is_supported(ir[6:0]);

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .ir  (ir),
    .imm (imm)
  );

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Scoreboard bench for instr_fetch_decode: stimulus pushes expected fetch results, a monitor checks each completion.
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_start;
  logic [63:0] pc_in;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        busy;
  logic        instr_valid;
  logic        fetch_err;
  logic        illegal;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [63:0] imm;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [63:0] imm;
    logic        err;
    logic        ill;
    logic [63:0] addr;
  } exp_t;

  exp_t expq[$];
  int   checks   = 0;
  int   failures = 0;
  logic prev_valid = 1'b0;

  instr_fetch_decode dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_start (fetch_start),
    .pc_in       (pc_in),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .busy        (busy),
    .instr_valid (instr_valid),
    .fetch_err   (fetch_err),
    .illegal     (illegal),
    .opcode      (opcode),
    .rd          (rd),
    .funct3      (funct3),
    .rs1         (rs1),
    .rs2         (rs2),
    .funct7      (funct7),
    .imm         (imm)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every rising edge of instr_valid is one completed fetch to compare against the queue head.
  always @(negedge clk) begin
    if (!reset && instr_valid && !prev_valid) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        checkOutput({e.name, "_instr"}, {32'd0, funct7, rs2, rs1, funct3, rd, opcode}, {32'd0, e.instr});
        checkOutput({e.name, "_imm"}, imm, e.imm);
        checkOutput({e.name, "_err"}, {63'd0, fetch_err}, {63'd0, e.err});
        checkOutput({e.name, "_illegal"}, {63'd0, illegal}, {63'd0, e.ill});
        checkOutput({e.name, "_addr"}, imem_addr, e.addr);
      end
    end
    prev_valid <= reset ? 1'b0 : instr_valid;
  end

  task automatic pushExp(input string name, input logic [31:0] instr, input logic [63:0] eimm,
                         input logic err, input logic ill, input logic [63:0] addr);
    exp_t e;
    e.name = name; e.instr = instr; e.imm = eimm; e.err = err; e.ill = ill; e.addr = addr;
    expq.push_back(e);
  endtask

  // One aligned fetch answered after `waits` idle REQ cycles; also checks the request length.
  task automatic applyStimulus(input string name, input logic [63:0] pc, input logic [31:0] rdata,
                               input int waits, input logic [63:0] eimm, input logic ill);
    int n;
    pushExp(name, rdata, eimm, 1'b0, ill, pc);
    @(negedge clk);
    fetch_start = 1'b1;
    pc_in       = pc;
    @(negedge clk);
    fetch_start = 1'b0;
    n = 0;
    while (imem_req && n < 100) begin
      n++;
      imem_ready = (n > waits);
      imem_rdata = rdata;
      @(negedge clk);
    end
    imem_ready = 1'b0;
    checkOutput({name, "_req_cycles"}, 64'(n), 64'(waits + 1));
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic [6:0]  hold_op;
    logic [63:0] hold_imm;
    reset = 1'b1; fetch_start = 1'b0; pc_in = '0; imem_ready = 1'b0; imem_rdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    checkOutput("rst_req", {63'd0, imem_req}, 64'd0);
    checkOutput("rst_addr", imem_addr, 64'd0);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_valid", {63'd0, instr_valid}, 64'd0);
    checkOutput("rst_err", {63'd0, fetch_err}, 64'd0);
    checkOutput("rst_opcode", {57'd0, opcode}, 64'h13);
    checkOutput("rst_illegal", {63'd0, illegal}, 64'd0);

    // Misaligned start from IDLE: memory is never asked.
    pushExp("misaligned", 32'h00000013, 64'd0, 1'b1, 1'b0, 64'h102);
    @(negedge clk);
    fetch_start = 1'b1; pc_in = 64'h102;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      fetch_start = 1'b0;
      if (imem_req) n++;
    end
    checkOutput("misaligned_req_count", 64'(n), 64'd0);

    applyStimulus("zero_wait", 64'h100, 32'h00A30293, 0, 64'd10, 1'b0);
    applyStimulus("wait3", 64'h104, 32'hFE010113, 3, 64'hFFFF_FFFF_FFFF_FFE0, 1'b0);
    applyStimulus("branch", 64'h108, 32'hFE000EE3, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    applyStimulus("jal", 64'h10C, 32'h0080006F, 0, 64'd8, 1'b0);
    applyStimulus("lui", 64'h110, 32'h123452B7, 2, 64'h12345000, 1'b0);
    applyStimulus("store", 64'h114, 32'h00512423, 0, 64'd8, 1'b0);
    applyStimulus("rtype", 64'h118, 32'h00B50533, 0, 64'd0, 1'b0);
    applyStimulus("illegal", 64'h11C, 32'h0000007F, 0, 64'd0, 1'b1);

    // HOLD must ignore imem_ready and keep the decoded view stable.
    hold_op = opcode; hold_imm = imm;
    imem_ready = 1'b1; imem_rdata = 32'h00A30293;
    repeat (3) @(negedge clk);
    imem_ready = 1'b0;
    checkOutput("hold_stable", {imm[56:0], opcode}, {hold_imm[56:0], 7'h7F});
    checkOutput("hold_opcode", {57'd0, hold_op}, 64'h7F);

    // A second fetch_start while in REQ must not restart or move the address.
    pushExp("start_in_req", 32'h00A30293, 64'd10, 1'b0, 1'b0, 64'h300);
    @(negedge clk);
    fetch_start = 1'b1; pc_in = 64'h300;
    @(negedge clk);
    fetch_start = 1'b1; pc_in = 64'h400;
    @(negedge clk);
    fetch_start = 1'b0;
    checkOutput("start_in_req_addr", imem_addr, 64'h300);
    checkOutput("start_in_req_req", {63'd0, imem_req}, 64'd1);
    imem_ready = 1'b1; imem_rdata = 32'h00A30293;
    @(negedge clk);
    imem_ready = 1'b0;
    checkOutput("start_in_req_done", {63'd0, imem_req}, 64'd0);
    @(negedge clk);

    // Reset in the middle of REQ aborts; a late ready afterwards is ignored.
    @(negedge clk);
    fetch_start = 1'b1; pc_in = 64'h200;
    @(negedge clk);
    fetch_start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_req", {63'd0, imem_req}, 64'd0);
    checkOutput("abort_busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;
    imem_ready = 1'b1; imem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    imem_ready = 1'b0;
    @(negedge clk);
    checkOutput("abort_late_valid", {63'd0, instr_valid}, 64'd0);
    checkOutput("abort_late_opcode", {57'd0, opcode}, 64'h13);

    // fetch_start together with reset: reset wins.
    @(negedge clk);
    reset = 1'b1; fetch_start = 1'b1; pc_in = 64'h500;
    @(negedge clk);
    reset = 1'b0; fetch_start = 1'b0;
    checkOutput("rst_wins_req", {63'd0, imem_req}, 64'd0);
    checkOutput("rst_wins_addr", imem_addr, 64'd0);

`ifdef IFD_TIMEOUT_EN
    // Ready never comes: the request is dropped once the counter reaches MAX_WAIT (count 0..15 in REQ).
    pushExp("timeout", 32'h00000013, 64'd0, 1'b1, 1'b0, 64'h600);
    @(negedge clk);
    fetch_start = 1'b1; pc_in = 64'h600;
    @(negedge clk);
    fetch_start = 1'b0;
    n = 0;
    while (imem_req && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput("timeout_req_cycles", 64'(n), 64'd16);
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 64'(expq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
